pim_mc_ctrl: RTL and testbench

- Multi-channel PIM access controller, the next generation of the single-port PIM interface on the chip top.
- Sits between the core's data-bus PIM window and NUM_CH independent PIM macros.
- Buffers core requests, decodes the channel from address bits and issues one access per cycle.
- Tracks fixed-latency reads and returns read data in order, with response backpressure enforced through credits.

---
 rtl/pim_pkg.sv | 21 ++
 rtl/pim_sync_fifo.sv | 47 ++++
 rtl/pim_mc_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pim_mc_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// Shared types and helpers for the multi-channel PIM access controller.
package pim_pkg;

  localparam int PIM_XLEN   = 32;
  localparam int PIM_NUM_CH = 4;
  localparam int CH_W       = $clog2(PIM_NUM_CH);

  typedef struct packed {
    logic                we;
    logic [PIM_XLEN-1:0] addr;
    logic [PIM_XLEN-1:0] wdata;
  } pim_req_t;

  function automatic logic [PIM_NUM_CH-1:0] ch_onehot(input logic [PIM_XLEN-1:0] addr,
                                                      input int unsigned        lsb);
    logic [CH_W-1:0] ch_s;
    ch_s = addr[lsb +: CH_W];
    return {{(PIM_NUM_CH-1){1'b0}}, 1'b1} << ch_s;
  endfunction

endpackage

// File: rtl/pim_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; used for both request and response queues.
module pim_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;

  // Storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push && !full) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  assign rdata = mem_r[rd_ptr_r[AW-1:0]];
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/pim_mc_ctrl.sv
// Multi-channel PIM access controller: queues core requests, issues one access per
// cycle to the decoded channel and returns fixed-latency read data in order.
module pim_mc_ctrl
  import pim_pkg::*;
#(
  parameter int XLEN       = PIM_XLEN,
  parameter int NUM_CH     = PIM_NUM_CH,
  parameter int CH_SEL_LSB = 12,
  parameter int RD_LATENCY = 2,
  parameter int REQ_DEPTH  = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [XLEN-1:0]        req_addr_i,
  input  logic [XLEN-1:0]        req_wdata_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [XLEN-1:0]        resp_rdata_o,
  output logic [NUM_CH-1:0]      pim_en_o,
  output logic                   pim_we_o,
  output logic [XLEN-1:0]        pim_addr_o,
  output logic [XLEN-1:0]        pim_wd_o,
  input  logic [NUM_CH*XLEN-1:0] pim_rd_i,
  output logic                   busy_o
);

  localparam int QW    = $clog2(REQ_DEPTH) + 1;
  localparam int CNT_W = $clog2(RESP_DEPTH) + 1;
  localparam logic [CNT_W:0] RESP_LIM = RESP_DEPTH[CNT_W:0];

  pim_req_t          req_in_s;
  pim_req_t          req_head_s;
  logic              req_full_s;
  logic              req_empty_s;
  logic [QW-1:0]     req_count_s;
  logic              live_r;
  logic              issue_s;
  logic              issue_rd_s;
  logic              credit_ok_s;
  logic [CNT_W:0]    credit_sum_s;
  logic [CH_W-1:0]   issue_ch_r;
  logic [RD_LATENCY-1:0] pipe_v_r;
  logic [CH_W-1:0]   pipe_ch_r [RD_LATENCY];
  logic              capture_s;
  logic [XLEN-1:0]   cap_data_s;
  logic [CNT_W-1:0]  outstanding_r;
  logic              resp_full_s;
  logic              resp_empty_s;
  logic [CNT_W-1:0]  resp_count_s;
  logic              resp_pop_s;

  assign req_in_s = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};

  pim_sync_fifo #(.WIDTH($bits(pim_req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk(clk_i), .rst(rst_i),
    .push(req_valid_i && req_ready_o), .wdata(req_in_s),
    .pop(issue_s), .rdata(req_head_s),
    .full(req_full_s), .empty(req_empty_s), .count(req_count_s)
  );

  // Holds ready low while in reset and until the first clock after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) live_r <= 1'b0;
    else       live_r <= 1'b1;
  end

  assign req_ready_o = live_r && !req_full_s;

  // Credits count only registered state, so a same-cycle response pop frees nothing.
  assign credit_sum_s = {1'b0, outstanding_r} + {1'b0, resp_count_s};
  assign credit_ok_s  = !resp_full_s && (credit_sum_s < RESP_LIM);

  // Head-of-line issue decision; a stalled read blocks everything behind it.
  always_comb begin
    issue_s = 1'b0;
    if (!req_empty_s) begin
      if (req_head_s.we) issue_s = 1'b1;
      else               issue_s = credit_ok_s;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign issue_rd_s = issue_s && !req_head_s.we;

  // Issue registers; address and write data hold between accesses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pim_en_o   <= {NUM_CH{1'b0}};
      pim_we_o   <= 1'b0;
      pim_addr_o <= {XLEN{1'b0}};
      pim_wd_o   <= {XLEN{1'b0}};
      issue_ch_r <= {CH_W{1'b0}};
    end else if (issue_s) begin
      pim_en_o   <= ch_onehot(req_head_s.addr, CH_SEL_LSB);
      pim_we_o   <= req_head_s.we;
      pim_addr_o <= req_head_s.addr;
      pim_wd_o   <= req_head_s.wdata;
      issue_ch_r <= req_head_s.addr[CH_SEL_LSB +: CH_W];
    end else begin
      pim_en_o   <= {NUM_CH{1'b0}};
      pim_we_o   <= 1'b0;
    end
  end

  // Read pipeline: the last stage lines up with valid data on pim_rd_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_v_r <= {RD_LATENCY{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) pipe_ch_r[i] <= {CH_W{1'b0}};
    end else begin
      pipe_v_r[0]  <= (pim_en_o != {NUM_CH{1'b0}}) && !pim_we_o;
      pipe_ch_r[0] <= issue_ch_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v_r[i]  <= pipe_v_r[i-1];
        pipe_ch_r[i] <= pipe_ch_r[i-1];
      end
    end
  end

  assign capture_s = pipe_v_r[RD_LATENCY-1];

  // Channel read-data select for the capturing stage.
  always_comb begin
    cap_data_s = {XLEN{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (pipe_ch_r[RD_LATENCY-1] == CH_W'(c)) cap_data_s = pim_rd_i[c*XLEN +: XLEN];
      else                                     cap_data_s = cap_data_s;
    end
  end

  // Reads issued but not yet captured.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_r <= {CNT_W{1'b0}};
    end else begin
      case ({issue_rd_s, capture_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  assign resp_pop_s = resp_valid_o && resp_ready_i;

  pim_sync_fifo #(.WIDTH(XLEN), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk(clk_i), .rst(rst_i),
    .push(capture_s), .wdata(cap_data_s),
    .pop(resp_pop_s), .rdata(resp_rdata_o),
    .full(resp_full_s), .empty(resp_empty_s), .count(resp_count_s)
  );

  assign resp_valid_o = !resp_empty_s;
  assign busy_o = (req_count_s != {QW{1'b0}}) || (outstanding_r != {CNT_W{1'b0}}) ||
                  (resp_count_s != {CNT_W{1'b0}}) || (pim_en_o != {NUM_CH{1'b0}});

endmodule

// File: tb/tb_pim_mc_ctrl.sv
// Self-checking bench for pim_mc_ctrl: behavioural PIM macros, read-data scoreboard,
// a vector table for issue order and directed multi-cycle corner cases.
module tb_pim_mc_ctrl;

  localparam int L   = 2;
  localparam int NCH = 4;
  localparam int XL  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we;
  logic [XL-1:0]    req_addr, req_wdata;
  logic             resp_valid, resp_ready;
  logic [XL-1:0]    resp_rdata;
  logic [NCH-1:0]   pim_en;
  logic             pim_we;
  logic [XL-1:0]    pim_addr, pim_wd;
  logic [NCH*XL-1:0] pim_rd;
  logic             busy;

  always #5 clk = ~clk;

  pim_mc_ctrl #(.XLEN(XL), .NUM_CH(NCH), .CH_SEL_LSB(12), .RD_LATENCY(L),
                .REQ_DEPTH(4), .RESP_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .pim_en_o(pim_en), .pim_we_o(pim_we), .pim_addr_o(pim_addr), .pim_wd_o(pim_wd),
    .pim_rd_i(pim_rd), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_issued = 0, rd_popped = 0, max_infl = 0;
  logic [XL-1:0] exp_q [$];

  typedef struct {
    logic [NCH-1:0] en;
    logic           we;
    logic [XL-1:0]  addr;
    logic [XL-1:0]  wd;
    int             cyc;
  } iss_t;
  iss_t iss_q [$];

  typedef struct {
    logic           we;
    logic [XL-1:0]  addr;
    logic [XL-1:0]  wd;
    logic [NCH-1:0] exp_en;
  } vec_t;

  // Contents of the PIM macros as seen by reads.
  function automatic logic [XL-1:0] pim_data(input logic [XL-1:0] a);
    if (a == 32'h0000_2004) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [1:0] enc(input logic [NCH-1:0] en);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < NCH; i++) if (en[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural macros: read data is valid on pim_rd exactly L cycles after the strobe.
  logic [L-1:0]  tb_v;
  logic [1:0]    tb_ch [L];
  logic [XL-1:0] tb_d  [L];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_v <= '0;
    end else begin
      tb_v[0]  <= (|pim_en) && !pim_we;
      tb_ch[0] <= enc(pim_en);
      tb_d[0]  <= pim_data(pim_addr);
      for (int i = 1; i < L; i++) begin
        tb_v[i]  <= tb_v[i-1];
        tb_ch[i] <= tb_ch[i-1];
        tb_d[i]  <= tb_d[i-1];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++)
      pim_rd[c*XL +: XL] = (tb_v[L-1] && tb_ch[L-1] == 2'(c)) ? tb_d[L-1] : (32'hBAD0_0000 | c);
  end

  always @(posedge clk) cyc++;

  // Issue log, in-flight bound and response scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      rd_issued = 0;
      rd_popped = 0;
    end else begin
      if (|pim_en) begin
        iss_q.push_back('{pim_en, pim_we, pim_addr, pim_wd, cyc});
        chk("en_onehot", 64'($onehot(pim_en)), 64'd1);
        if (!pim_we) rd_issued++;
      end
      if (rd_issued - rd_popped > max_infl) max_infl = rd_issued - rd_popped;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'd0);
        else chk("resp_data", 64'(resp_rdata), 64'(exp_q.pop_front()));
        rd_popped++;
      end
    end
  end

  // One request handshake; the expected read data enters the scoreboard on acceptance.
  task automatic push_req(input logic we, input logic [XL-1:0] a, input logic [XL-1:0] d);
    int t;
    t = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && t < 500) begin
      step();
      t++;
    end
    if (t >= 500) chk("req_timeout", 64'(req_ready), 64'd1);
    else if (!we) exp_q.push_back(pim_data(a));
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      step();
      t++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_en"},    64'(pim_en), 64'd0);
    chk({nm, "_we"},    64'(pim_we), 64'd0);
    chk({nm, "_addr"},  64'(pim_addr), 64'd0);
    chk({nm, "_wd"},    64'(pim_wd), 64'd0);
    chk({nm, "_rvld"},  64'(resp_valid), 64'd0);
    chk({nm, "_rdata"}, 64'(resp_rdata), 64'd0);
    chk({nm, "_ready"}, 64'(req_ready), 64'd0);
    chk({nm, "_busy"},  64'(busy), 64'd0);
  endtask

  vec_t vecs [7];
  bit   rand_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    repeat (2) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Single read on channel 2: strobe in cycle 2, response in cycle 5.
    push_req(1'b0, 32'h0000_2004, 32'h0);
    chk("rd1_en_c1", 64'(pim_en), 64'd0);
    step();
    chk("rd1_en_c2", 64'(pim_en), 64'b0100);
    chk("rd1_we_c2", 64'(pim_we), 64'd0);
    chk("rd1_addr_c2", 64'(pim_addr), 64'h2004);
    step();
    chk("rd1_rvld_c3", 64'(resp_valid), 64'd0);
    step();
    chk("rd1_rvld_c4", 64'(resp_valid), 64'd0);
    step();
    chk("rd1_rvld_c5", 64'(resp_valid), 64'd1);
    chk("rd1_rdata_c5", 64'(resp_rdata), 64'hDEAD_BEEF);
    wait_idle();

    // Back-to-back writes then mixed read/write/read; all issue on consecutive cycles.
    vecs[0] = '{1'b1, 32'h0000_0000, 32'h1111_0000, 4'b0001};
    vecs[1] = '{1'b1, 32'h0000_1000, 32'h2222_1111, 4'b0010};
    vecs[2] = '{1'b1, 32'h0000_2000, 32'h3333_2222, 4'b0100};
    vecs[3] = '{1'b1, 32'h0000_3000, 32'h4444_3333, 4'b1000};
    vecs[4] = '{1'b0, 32'h0000_1010, 32'h0000_0000, 4'b0010};
    vecs[5] = '{1'b1, 32'h0000_3020, 32'hCAFE_F00D, 4'b1000};
    vecs[6] = '{1'b0, 32'h0000_0030, 32'h0000_0000, 4'b0001};
    iss_q.delete();
    for (int i = 0; i < 7; i++) push_req(vecs[i].we, vecs[i].addr, vecs[i].wd);
    wait_idle();
    chk("vec_issue_count", 64'(iss_q.size()), 64'd7);
    for (int i = 0; i < 7 && i < iss_q.size(); i++) begin
      chk($sformatf("vec%0d_en", i), 64'(iss_q[i].en), 64'(vecs[i].exp_en));
      chk($sformatf("vec%0d_we", i), 64'(iss_q[i].we), 64'(vecs[i].we));
      chk($sformatf("vec%0d_addr", i), 64'(iss_q[i].addr), 64'(vecs[i].addr));
      if (vecs[i].we) chk($sformatf("vec%0d_wd", i), 64'(iss_q[i].wd), 64'(vecs[i].wd));
      chk($sformatf("vec%0d_cycle", i), 64'(iss_q[i].cyc - iss_q[0].cyc), 64'(i));
    end

    // Backpressure: 4 reads issue on credits, 4 more fill the request queue.
    resp_ready = 1'b0;
    iss_q.delete();
    for (int i = 0; i < 8; i++) push_req(1'b0, 32'(i * 32'h1000 + 32'h40 + i * 4), 32'h0);
    repeat (6) step();
    chk("bp_issued", 64'(iss_q.size()), 64'd4);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rvld_hold", 64'(resp_valid), 64'd1);
      chk("bp_rdata_hold", 64'(resp_rdata), 64'(exp_q[0]));
      step();
    end
    resp_ready = 1'b1;
    wait_idle();
    chk("bp_all_resp", 64'(exp_q.size()), 64'd0);
    chk("bp_total_issued", 64'(iss_q.size()), 64'd8);

    // Reset in the cycle after a read strobe drops the access completely.
    push_req(1'b0, 32'h0000_1100, 32'h0);
    step();
    chk("rst_en_c2", 64'(pim_en), 64'b0010);
    step();
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("midrst_no_rvld", 64'(resp_valid), 64'd0);
    end
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);

    // Random reads with random response backpressure.
    rand_done = 1'b0;
    max_infl = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          push_req(1'b0, $urandom & 32'h0000_3FFC, 32'h0);
          if ($urandom_range(0, 3) == 0) step();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          resp_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    resp_ready = 1'b1;
    wait_idle();
    chk("rand_all_resp", 64'(exp_q.size()), 64'd0);
    chk("rand_inflight_le_depth", 64'(max_infl <= 4), 64'd1);
    chk("rand_inflight_reached", 64'(max_infl >= 2), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
